// File: rtl/scramble_solve_if.sv
// Board-side bus of the scramble/solve controller: mode and button inputs,
// the random-source handshake, move output and game status.
interface scramble_solve_if #(
  parameter int unsigned RAND_W = 5,
  parameter int unsigned MD_W   = 5
);
  logic              mix_state;
  logic              scramble_btn;
  logic              rand_ack;
  logic [RAND_W-1:0] rand_val;
  logic              solved;
  logic              rand_req;
  logic              move_valid;
  logic [RAND_W-1:0] move_idx;
  logic [MD_W-1:0]   moves_done;
  logic              no_buzz;
  logic              busy;
  logic              won;
  logic              timeout;

  modport ctrl (
    input  mix_state, scramble_btn, rand_ack, rand_val, solved,
    output rand_req, move_valid, move_idx, moves_done, no_buzz, busy, won, timeout
  );

  modport host (
    output mix_state, scramble_btn, rand_ack, rand_val, solved,
    input  rand_req, move_valid, move_idx, moves_done, no_buzz, busy, won, timeout
  );
endinterface

// File: rtl/scramble_solve_ctrl.sv
// Game-flow controller: issues MOVE_COUNT handshaked random moves, then
// supervises the solve phase with buzzer enable, timeout and win flag.
module scramble_solve_ctrl #(
  parameter int unsigned MOVE_COUNT     = 31,
  parameter int unsigned RAND_W         = 5,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input logic            clk,
  input logic            rst_n,
  scramble_solve_if.ctrl bus
);
  localparam int unsigned MD_W = $clog2(MOVE_COUNT + 1);
  localparam int unsigned TW   = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {IDLE, REQ, APPLY, SOLVE, DONE} state_t;

  state_t            state, state_n;
  logic              btn_q;
  logic              rise;
  logic [TW-1:0]     timer, timer_n;
  logic [MD_W-1:0]   moves_q, moves_n;
  logic [RAND_W-1:0] idx_q, idx_n;
  logic              timeout_n;
  logic              rand_req_q, move_valid_q, no_buzz_q, busy_q, won_q, timeout_q;

  // btn_q resets high so a button held through reset release is not an edge
  assign rise = bus.scramble_btn & ~btn_q;

  // Next state and datapath; mix_state low aborts from anywhere
  always_comb begin
    state_n   = state;
    timer_n   = timer;
    moves_n   = moves_q;
    idx_n     = idx_q;
    timeout_n = 1'b0;
    if (!bus.mix_state) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (rise) begin
            state_n = REQ;
            moves_n = '0;
          end
        end
        REQ: begin
          if (bus.rand_ack) begin
            idx_n   = bus.rand_val;
            state_n = APPLY;
          end
        end
        APPLY: begin
          if (moves_q != MD_W'(MOVE_COUNT)) moves_n = moves_q + MD_W'(1);
          if (moves_q == MD_W'(MOVE_COUNT - 1)) begin
            state_n = SOLVE;
            timer_n = '0;
          end else begin
            state_n = REQ;
          end
        end
        SOLVE: begin
          if (bus.solved) begin
            state_n = DONE;
          end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
            state_n   = IDLE;
            timeout_n = 1'b1;
          end else if (rise) begin
            state_n = REQ;
            moves_n = '0;
            timer_n = '0;
          end else begin
            timer_n = timer + TW'(1);
          end
        end
        DONE: begin
          if (rise) begin
            state_n = REQ;
            moves_n = '0;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // State, datapath and outputs registered from the next-state decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      btn_q        <= 1'b1;
      timer        <= '0;
      moves_q      <= '0;
      idx_q        <= '0;
      rand_req_q   <= 1'b0;
      move_valid_q <= 1'b0;
      no_buzz_q    <= 1'b1;
      busy_q       <= 1'b0;
      won_q        <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state        <= state_n;
      btn_q        <= bus.scramble_btn;
      timer        <= timer_n;
      moves_q      <= moves_n;
      idx_q        <= idx_n;
      rand_req_q   <= (state_n == REQ);
      move_valid_q <= (state_n == APPLY);
      no_buzz_q    <= (state_n != SOLVE);
      busy_q       <= (state_n == REQ) || (state_n == APPLY);
      won_q        <= (state_n == DONE);
      timeout_q    <= timeout_n;
    end
  end

  assign bus.rand_req   = rand_req_q;
  assign bus.move_valid = move_valid_q;
  assign bus.move_idx   = idx_q;
  assign bus.moves_done = moves_q;
  assign bus.no_buzz    = no_buzz_q;
  assign bus.busy       = busy_q;
  assign bus.won        = won_q;
  assign bus.timeout    = timeout_q;
endmodule

// File: doc/scramble_solve_ctrl.md
# scramble_solve_ctrl

Parametrised game-flow controller for the puzzle board. Sequences a full scramble (N handshaked random moves from the random-number source), then supervises the solve phase with buzzer enable, a solve timeout and a win flag. Sits between the mode/button inputs and the move-apply and buzzer logic. Generalises the earlier combinational shuffle/solve decode with a real state machine, a move counter and a request/acknowledge handshake.

## Interface
- MOVE_COUNT, 31: random moves issued per scramble (>=1)
- RAND_W, 5: width of random value / move index
- TIMEOUT_CYCLES, 1000: solve-phase cycles before timeout (>=2)

- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- mix_state  in  1  game mode enable; low forces idle/abort
- scramble_btn  in  1  scramble request button, already synchronised, level
- rand_ack  in  1  random source: rand_val valid this cycle
- rand_val  in  RAND_W  random value from source
- solved  in  1  board reports solved configuration
- rand_req  out  1  request for one random value
- move_valid  out  1  one-cycle pulse: apply move_idx
- move_idx  out  RAND_W  captured random move
- moves_done  out  $clog2(MOVE_COUNT+1)  moves issued in current scramble
- no_buzz  out  1  high = buzzer suppressed
- busy  out  1  high in REQ/APPLY
- won  out  1  high in DONE
- timeout  out  1  one-cycle pulse on solve timeout

## Operation
- Button edge: btn_q register (reset 1); rise = scramble_btn & ~btn_q. Button held through reset release produces no start.
- States: IDLE, REQ, APPLY, SOLVE, DONE. Reset -> IDLE.
- Global priority: mix_state=0 in any state -> IDLE next edge; overrides ack, solved, timeout, rise. In-flight move discarded (no move_valid).
- IDLE: no_buzz=1. rise & mix_state -> REQ, moves_done cleared to 0.
- REQ: rand_req=1. rand_ack=1 -> capture move_idx<=rand_val, -> APPLY. Otherwise hold; no timeout on handshake.
- APPLY: move_valid=1 for exactly one cycle; moves_done increments on leaving. If moves_done (pre-increment) == MOVE_COUNT-1 -> SOLVE with timer cleared; else -> REQ.
- SOLVE: no_buzz=0. Timer increments each cycle. solved=1 -> DONE (solved wins over timeout on same edge). Timer == TIMEOUT_CYCLES-1 -> IDLE, timeout pulses. rise -> REQ (restart, moves_done cleared, timer cleared); solved has priority over rise.
- DONE: no_buzz=1, won=1. rise -> REQ (new game, moves_done cleared). Holds otherwise.
- rand_ack outside REQ ignored. rise in REQ/APPLY ignored.
- Timer width $clog2(TIMEOUT_CYCLES); never wraps (leaves SOLVE at terminal value). moves_done saturates at MOVE_COUNT and holds until next scramble start.

## Timing
- All outputs registered; reset values: rand_req 0, move_valid 0, move_idx 0, moves_done 0, no_buzz 1, busy 0, won 0, timeout 0.
- Rise sampled at edge k -> rand_req high from edge k+1.
- rand_ack sampled high at edge m -> rand_req low and move_valid high for cycle after m, move_idx valid same cycle and held until next capture; rand_req high again after edge m+1.
- Minimum 2 cycles per move; minimum scramble 2*MOVE_COUNT cycles from first rand_req to SOLVE.
- rand_ack with rand_req high is the only accepted handshake; each ack consumes exactly one value.
- mix_state fall at edge k -> all outputs at idle values after edge k.
- Async reset asserts outputs to reset values immediately, independent of clk.

## Test plan
- MOVE_COUNT=3, rand_ack tied 1, rand_val 5,9,17 -> three move_valid pulses with move_idx 5,9,17 at 2-cycle spacing, moves_done 3, no_buzz falls on SOLVE entry.
- rand_ack delayed 4 cycles per request -> rand_req held 5 cycles each, no extra move_valid, exactly MOVE_COUNT moves.
- SOLVE with solved asserted on cycle 10 -> DONE, won=1, no_buzz=1, timeout stays 0; solved and timer terminal on same edge -> DONE, no timeout pulse.
- TIMEOUT_CYCLES=8, solved never -> timeout pulse after 8 SOLVE cycles, IDLE, no_buzz=1.
- mix_state dropped mid-REQ after 2 moves -> IDLE next edge, rand_req 0, no move_valid; later rise -> moves_done restarts at 0.
- scramble_btn held high across rst_n release -> no start; rst_n asserted during APPLY -> all outputs reset values immediately.
